fwd_unit: RTL and testbench
===========================

# fwd_unit

Forwarding control unit for the 5-stage RISC-V pipeline. Tracks the destination register of the instructions in EXE and MEM, compares them against the source registers of the instruction leaving ID, and produces registered `rs_sel`/`rt_sel` codes. These codes drive the EXE-stage operand muxes during the cycle the instruction is in EXE. The block sits between the ID/EXE pipeline register and the EXE operand muxes, and also keeps a saturating forward-event counter for performance monitoring.

## Interface
- `REG_AW`, default 5: register-index width.
- `CNT_W`, default 32: forward-event counter width.
- `clk`  in  1  pipeline clock.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  global pipeline freeze (I/D-cache miss); all state holds.
- `flush_EXE`  in  1  branch/jump redirect; instruction leaving ID is killed (bubble into EXE).
- `valid_ID`  in  1  ID holds a real instruction.
- `rs1_ID`  in  REG_AW  source register 1 of the ID instruction.
- `rs2_ID`  in  REG_AW  source register 2 of the ID instruction.
- `rd_ID`  in  REG_AW  destination register of the ID instruction.
- `reg_write_ID`  in  1  ID instruction writes `rd`.
- `mem_read_ID`  in  1  ID instruction is a load.
- `rs_sel`  out  2  operand-1 source select for the EXE instruction.
- `rt_sel`  out  2  operand-2 source select for the EXE instruction.
- `fwd_cnt`  out  CNT_W  number of non-00 selects issued, saturating.

## Operation
- Select encoding, shared by `rs_sel` and `rt_sel`:
  - 00: register-file read data.
  - 01: `alu_result_MEM`.
  - 10: WB `write_data`.
  - 11: `Dcache_out_ext`, i.e. load data in MEM.
- Two tracking entries, `ex_q` and `mem_q`. Each holds {valid, rd, reg_write, mem_read}.
- On every edge with `stall`=0:
  - `mem_q` <= `ex_q`.
  - `ex_q` <= ID fields, with valid = `valid_ID & ~flush_EXE`.
- Per source `s` (rs1, rs2), select computed at the same edge and registered into `rs_sel`/`rt_sel`:
  - `s`==0: code 00.
  - Else, if `ex_q` valid, reg_write, and rd==`s`: code 11 if `ex_q`.mem_read, otherwise 01. The EXE instruction will be in MEM next cycle.
  - Else, if `mem_q` valid, reg_write, and rd==`s`: code 10. The MEM instruction will be in WB next cycle.
  - Else: code 00. The register file is write-first, so a WB-stage producer is covered inside the register file.
- Priority: the youngest producer (`ex_q`) wins over `mem_q`.
- When the killed/invalid ID slot is captured (flush or `valid_ID`=0), both selects register as 00.
- `fwd_cnt` increments by the number of non-00 selects being registered (0, 1 or 2) and saturates at all-ones.

## Timing
- Reset (`rst`=1 at an edge): `rs_sel`=00, `rt_sel`=00, `fwd_cnt`=0, both tracking entries invalid. Reset overrides `stall` and `flush_EXE`.
- Latency: selects are valid one cycle after the instruction is presented in ID, for the full EXE cycle. Outputs are register outputs with no combinational path from inputs.
- `stall`=1: tracking entries, selects and counter all hold. `flush_EXE` is ignored that cycle; the producer holds it until `stall` falls.
- Simultaneous `flush_EXE`=1 and `valid_ID`=1 with `stall`=0: a bubble enters EXE. `ex_q` still advances to `mem_q`, so older instructions are unaffected.
- rs1==rs2 matching the same producer: both selects take the same code and the counter increments by 2.
- Counter at all-ones plus another event: stays all-ones.

## Structure
- Package `fwd_pkg` holds:
  - `fwd_sel_e` (2-bit enum: `FWD_RF`, `FWD_ALU_MEM`, `FWD_WB`, `FWD_LOAD_MEM`).
  - `stage_info_t` packed struct {valid, rd, reg_write, mem_read}.
  - `REG_AW` default.
- Sub-module `fwd_match`: combinational, takes one source index plus `ex_q`/`mem_q` and returns a `fwd_sel_e`. It is instantiated twice, for rs1 and rs2.
- `data_size`-style macros stay in `define.sv`. This block carries no datapath.

## Test plan
- Reset: assert `rst` with `stall`=1 and random inputs -> next cycle `rs_sel`=`rt_sel`=00, `fwd_cnt`=0.
- ALU back-to-back: `add x5` then `sub x6,x5,x5`, no stall -> for `sub` in EXE: `rs_sel`=`rt_sel`=01, `fwd_cnt`=2.
- Load then use: `lw x7` then `add x8,x7,x1` -> `rs_sel`=11, `rt_sel`=00. With `add x9,x1,x7` following one slot later -> `rt_sel`=10.
- Priority and x0:
  - `add x3`, `add x3`, then `or x4,x3,x0` -> `rs_sel`=01 (younger producer), `rt_sel`=00.
  - `addi x0` as producer never forwards.
- Stall/flush: producer `add x5`, hold `stall`=1 for 3 cycles with `flush_EXE` pulsed mid-stall -> selects and `fwd_cnt` frozen, flush ignored. Then `flush_EXE` with `stall`=0 -> bubble yields 00/00, and the following consumer of x5 gets 10.
- Saturation: preload `CNT_W`=4, drive 8 double-forward consumers -> `fwd_cnt` stops at 15.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared types for the EXE-stage operand forwarding unit.
// Select codes match the operand mux encoding in EXE.
package fwd_pkg;

    localparam int REG_AW_DEF = 5;

    typedef enum logic [1:0] {
        FWD_RF       = 2'b00,
        FWD_ALU_MEM  = 2'b01,
        FWD_WB       = 2'b10,
        FWD_LOAD_MEM = 2'b11
    } fwd_sel_e;

    typedef struct packed {
        logic                  valid;
        logic [REG_AW_DEF-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
    } stage_info_t;

endpackage

// File: rtl/fwd_match.sv
// Per-source forward select: youngest producer wins, x0 never forwards.
// Purely combinational; one copy per source operand.
module fwd_match
    import fwd_pkg::*;
(
    input  logic [REG_AW_DEF-1:0] i_src,
    input  stage_info_t           i_ex,
    input  stage_info_t           i_mem,
    output fwd_sel_e              o_sel
);

    logic w_ex_hit;
    logic w_mem_hit;

    assign w_ex_hit  = i_ex.valid && i_ex.reg_write && (i_ex.rd == i_src);
    assign w_mem_hit = i_mem.valid && i_mem.reg_write && (i_mem.rd == i_src);

    // EXE producer (next in MEM) beats MEM producer (next in WB)
    always_comb begin
        o_sel = FWD_RF;
        if (i_src == '0) begin
            o_sel = FWD_RF;
        end else if (w_ex_hit) begin
            o_sel = i_ex.mem_read ? FWD_LOAD_MEM : FWD_ALU_MEM;
        end else if (w_mem_hit) begin
            o_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/fwd_unit.sv
// Forwarding control: tracks EXE/MEM destinations and registers the
// operand selects for the instruction entering EXE, plus an event counter.
module fwd_unit
    import fwd_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush_EXE,
    input  logic              valid_ID,
    input  logic [REG_AW-1:0] rs1_ID,
    input  logic [REG_AW-1:0] rs2_ID,
    input  logic [REG_AW-1:0] rd_ID,
    input  logic              reg_write_ID,
    input  logic              mem_read_ID,
    output logic [1:0]        rs_sel,
    output logic [1:0]        rt_sel,
    output logic [CNT_W-1:0]  fwd_cnt
);

    stage_info_t      r_ex;
    stage_info_t      r_mem;
    fwd_sel_e         r_rs_sel;
    fwd_sel_e         r_rt_sel;
    logic [CNT_W-1:0] r_cnt;

    stage_info_t      w_ex_next;
    fwd_sel_e         w_rs_match;
    fwd_sel_e         w_rt_match;
    fwd_sel_e         w_rs_next;
    fwd_sel_e         w_rt_next;
    logic [1:0]       w_inc;
    logic [CNT_W:0]   w_sum;
    logic [CNT_W-1:0] w_cnt_next;

    // Slot captured into EXE; a flush turns it into a bubble
    always_comb begin
        w_ex_next           = '0;
        w_ex_next.valid     = valid_ID & ~flush_EXE;
        w_ex_next.rd        = rd_ID;
        w_ex_next.reg_write = reg_write_ID;
        w_ex_next.mem_read  = mem_read_ID;
    end

    fwd_match u_match_rs (
        .i_src (rs1_ID),
        .i_ex  (r_ex),
        .i_mem (r_mem),
        .o_sel (w_rs_match)
    );

    fwd_match u_match_rt (
        .i_src (rs2_ID),
        .i_ex  (r_ex),
        .i_mem (r_mem),
        .o_sel (w_rt_match)
    );

    // Bubbles never forward; count non-RF selects with saturation
    always_comb begin
        w_rs_next  = w_ex_next.valid ? w_rs_match : FWD_RF;
        w_rt_next  = w_ex_next.valid ? w_rt_match : FWD_RF;
        w_inc      = {1'b0, w_rs_next != FWD_RF}
                   + {1'b0, w_rt_next != FWD_RF};
        w_sum      = {1'b0, r_cnt} + (CNT_W+1)'(w_inc);
        w_cnt_next = w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
    end

    // Pipeline tracking, selects and counter; everything holds on stall
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex     <= '0;
            r_mem    <= '0;
            r_rs_sel <= FWD_RF;
            r_rt_sel <= FWD_RF;
            r_cnt    <= '0;
        end else if (!stall) begin
            r_mem    <= r_ex;
            r_ex     <= w_ex_next;
            r_rs_sel <= w_rs_next;
            r_rt_sel <= w_rt_next;
            r_cnt    <= w_cnt_next;
        end
    end

    assign rs_sel  = r_rs_sel;
    assign rt_sel  = r_rt_sel;
    assign fwd_cnt = r_cnt;

endmodule

// File: tb/tb_fwd_unit.sv
// Directed vector bench for fwd_unit with a 4-bit counter so that
// saturation is reachable in a handful of cycles.
module tb_fwd_unit;

    logic       clk;
    logic       rst;
    logic       stall;
    logic       flush_EXE;
    logic       valid_ID;
    logic [4:0] rs1_ID;
    logic [4:0] rs2_ID;
    logic [4:0] rd_ID;
    logic       reg_write_ID;
    logic       mem_read_ID;
    logic [1:0] rs_sel;
    logic [1:0] rt_sel;
    logic [3:0] fwd_cnt;

    int n_vec;
    int n_bad;

    typedef struct {
        logic       rst;
        logic       stall;
        logic       flush;
        logic       valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
        logic [1:0] ers;
        logic [1:0] ert;
        logic [3:0] ecnt;
    } vec_t;

    vec_t tbl[$];

    fwd_unit #(
        .REG_AW (5),
        .CNT_W  (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush_EXE    (flush_EXE),
        .valid_ID     (valid_ID),
        .rs1_ID       (rs1_ID),
        .rs2_ID       (rs2_ID),
        .rd_ID        (rd_ID),
        .reg_write_ID (reg_write_ID),
        .mem_read_ID  (mem_read_ID),
        .rs_sel       (rs_sel),
        .rt_sel       (rt_sel),
        .fwd_cnt      (fwd_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic r, input logic s, input logic f, input logic v,
        input int a, input int b, input int d,
        input logic w, input logic m,
        input logic [1:0] ers, input logic [1:0] ert, input int ec
    );
        vec_t t;
        t.rst   = r;
        t.stall = s;
        t.flush = f;
        t.valid = v;
        t.rs1   = 5'(a);
        t.rs2   = 5'(b);
        t.rd    = 5'(d);
        t.rw    = w;
        t.mr    = m;
        t.ers   = ers;
        t.ert   = ert;
        t.ecnt  = 4'(ec);
        return t;
    endfunction

    task automatic step(input string nm, input vec_t t);
        rst          = t.rst;
        stall        = t.stall;
        flush_EXE    = t.flush;
        valid_ID     = t.valid;
        rs1_ID       = t.rs1;
        rs2_ID       = t.rs2;
        rd_ID        = t.rd;
        reg_write_ID = t.rw;
        mem_read_ID  = t.mr;
        @(posedge clk);
        #1;
        n_vec++;
        if (rs_sel !== t.ers || rt_sel !== t.ert || fwd_cnt !== t.ecnt) begin
            n_bad++;
            $display("FAIL %s: got rs=%b rt=%b cnt=%0d, want rs=%b rt=%b cnt=%0d",
                     nm, rs_sel, rt_sel, fwd_cnt, t.ers, t.ert, t.ecnt);
        end
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;

        // reset under stall with arbitrary ID contents
        tbl.push_back(mk(1, 1, $urandom_range(0, 1), 1,
                         $urandom_range(1, 31), $urandom_range(1, 31),
                         $urandom_range(1, 31), 1, $urandom_range(0, 1),
                         2'b00, 2'b00, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
        // add x5 ; sub x6,x5,x5
        tbl.push_back(mk(0, 0, 0, 1, 1, 2, 5, 1, 0, 2'b00, 2'b00, 0));
        tbl.push_back(mk(0, 0, 0, 1, 5, 5, 6, 1, 0, 2'b01, 2'b01, 2));
        // lw x7 ; add x8,x7,x1 ; add x9,x1,x7
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 7, 1, 1, 2'b00, 2'b00, 2));
        tbl.push_back(mk(0, 0, 0, 1, 7, 1, 8, 1, 0, 2'b11, 2'b00, 3));
        tbl.push_back(mk(0, 0, 0, 1, 1, 7, 9, 1, 0, 2'b00, 2'b10, 4));
        // add x3 ; add x3 ; or x4,x3,x0
        tbl.push_back(mk(0, 0, 0, 1, 1, 2, 3, 1, 0, 2'b00, 2'b00, 4));
        tbl.push_back(mk(0, 0, 0, 1, 1, 2, 3, 1, 0, 2'b00, 2'b00, 4));
        tbl.push_back(mk(0, 0, 0, 1, 3, 0, 4, 1, 0, 2'b01, 2'b00, 5));
        // addi x0 ; add x10,x0,x0
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 1, 0, 2'b00, 2'b00, 5));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 10, 1, 0, 2'b00, 2'b00, 5));
        // invalid ID slot reading x10, then a real reader of x10
        tbl.push_back(mk(0, 0, 0, 0, 10, 10, 10, 1, 0, 2'b00, 2'b00, 5));
        tbl.push_back(mk(0, 0, 0, 1, 10, 1, 12, 1, 0, 2'b10, 2'b00, 6));
        // store (no reg_write) that reads x12, then readers past it
        tbl.push_back(mk(0, 0, 0, 1, 12, 12, 12, 0, 0, 2'b01, 2'b01, 8));
        tbl.push_back(mk(0, 0, 0, 1, 12, 1, 13, 1, 0, 2'b10, 2'b00, 9));
        tbl.push_back(mk(0, 0, 0, 1, 12, 13, 14, 1, 0, 2'b00, 2'b01, 10));
        // add x5, then 3 stalled cycles with a flush pulse in the middle
        tbl.push_back(mk(0, 0, 0, 1, 1, 2, 5, 1, 0, 2'b00, 2'b00, 10));
        tbl.push_back(mk(0, 1, 0, 1, 5, 5, 15, 1, 0, 2'b00, 2'b00, 10));
        tbl.push_back(mk(0, 1, 1, 1, 5, 5, 15, 1, 0, 2'b00, 2'b00, 10));
        tbl.push_back(mk(0, 1, 0, 1, 5, 5, 15, 1, 0, 2'b00, 2'b00, 10));
        // flush kills the consumer; next consumer sees x5 in MEM
        tbl.push_back(mk(0, 0, 1, 1, 5, 5, 15, 1, 0, 2'b00, 2'b00, 10));
        tbl.push_back(mk(0, 0, 0, 1, 5, 5, 15, 1, 0, 2'b10, 2'b10, 12));
        // double forwards run the counter into saturation
        tbl.push_back(mk(0, 0, 0, 1, 15, 15, 16, 1, 0, 2'b01, 2'b01, 14));
        tbl.push_back(mk(0, 0, 0, 1, 16, 16, 17, 1, 0, 2'b01, 2'b01, 15));
        tbl.push_back(mk(0, 0, 0, 1, 17, 17, 18, 1, 0, 2'b01, 2'b01, 15));
        // reset wins over stall and flush
        tbl.push_back(mk(1, 1, 1, 1, 18, 18, 19, 1, 0, 2'b00, 2'b00, 0));

        foreach (tbl[i]) step($sformatf("vec%0d", i), tbl[i]);

        // fresh reset, producer x1, then 8 chained double-forward consumers
        step("sat_rst", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
        step("sat_prod", mk(0, 0, 0, 1, 0, 0, 1, 1, 0, 2'b00, 2'b00, 0));
        for (int k = 1; k <= 8; k++) begin
            int ec;
            ec = (2 * k > 15) ? 15 : 2 * k;
            step($sformatf("sat%0d", k),
                 mk(0, 0, 0, 1, k, k, k + 1, 1, 0, 2'b01, 2'b01, ec));
        end

        // load in MEM plus ALU in EXE on different sources
        step("mix_ld", mk(0, 0, 0, 1, 0, 0, 20, 1, 1, 2'b00, 2'b00, 15));
        step("mix_alu", mk(0, 0, 0, 1, 0, 0, 21, 1, 0, 2'b00, 2'b00, 15));
        step("mix_use", mk(0, 0, 0, 1, 21, 20, 22, 1, 0, 2'b01, 2'b10, 15));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
